tile_feed_sequencer_a: RTL and testbench

Sequences operand-A tile streaming for the systolic array's A-side buffer. Per start command it walks the WS tile loop (iter_t outer, iter_i inner). For each tile it drives the A address generator's `on`, `base_addr` and `num_rows` inputs: `on` is held for exactly `cfg_depth` cycles, and `base_addr`/`num_rows` stay stable until the skewed wavefront of the last array row has fully drained.

---
 rtl/systolic_pkg.sv | 19 +
 rtl/nested_iter_counter.sv | 56 +++++
 rtl/tile_feed_sequencer_a.sv | 182 ++++++++++++++++++
 tb/tb_tile_feed_sequencer_a.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feed sequencers.
package systolic_pkg;

  localparam int CNT_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  // Width of a row count that must hold the value array_n itself.
  function automatic int num_rows_w(input int array_n);
    return $clog2(array_n) + 1;
  endfunction

endpackage

// File: rtl/nested_iter_counter.sv
// Two-level wrap counter: iter_i runs inner, iter_t advances when iter_i wraps.
// wrap_i and last describe the current position so the owner can decide what
// the next advance does before it happens.
module nested_iter_counter
  import systolic_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [CNT_WIDTH-1:0] max_i,
  input  logic [CNT_WIDTH-1:0] max_t,
  output logic                 wrap_i,
  output logic                 last
);

  logic [CNT_WIDTH-1:0] iter_i_d, iter_i_q;
  logic [CNT_WIDTH-1:0] iter_t_d, iter_t_q;

  assign wrap_i = (iter_i_q == (max_i - CNT_WIDTH'(1)));
  assign last   = wrap_i && (iter_t_q == (max_t - CNT_WIDTH'(1)));

  // Next position: clear to the origin, or step the inner index with carry.
  always_comb begin
    iter_i_d = iter_i_q;
    iter_t_d = iter_t_q;
    if (clear) begin
      iter_i_d = '0;
      iter_t_d = '0;
    end else if (advance) begin
      if (wrap_i) begin
        iter_i_d = '0;
        iter_t_d = iter_t_q + CNT_WIDTH'(1);
      end else begin
        iter_i_d = iter_i_q + CNT_WIDTH'(1);
      end
    end else begin
      iter_i_d = iter_i_q;
      iter_t_d = iter_t_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_i_q <= '0;
      iter_t_q <= '0;
    end else begin
      iter_i_q <= iter_i_d;
      iter_t_q <= iter_t_d;
    end
  end

endmodule

// File: rtl/tile_feed_sequencer_a.sv
// Operand-A tile sequencer: walks the (iter_t, iter_i) tile loop and drives the
// A address generator with on/base_addr/num_rows, holding the address inputs
// until the skewed wavefront of the last array row has drained.
module tile_feed_sequencer_a
  import systolic_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int ARRAY_N    = 8,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [CNT_WIDTH-1:0]              cfg_depth,
  input  logic [CNT_WIDTH-1:0]              cfg_iter_i,
  input  logic [CNT_WIDTH-1:0]              cfg_iter_t,
  input  logic [CNT_WIDTH-1:0]              cfg_rows,
  input  logic                              tile_ready,
  output logic                              on,
  output logic [ADDR_WIDTH-1:0]             base_addr,
  output logic [num_rows_w(ARRAY_N)-1:0]    num_rows,
  output logic                              busy,
  output logic                              done
);

  localparam int NRW = num_rows_w(ARRAY_N);

  seq_state_e           state_d, state_q;
  logic [CNT_WIDTH-1:0] depth_d, depth_q;
  logic [CNT_WIDTH-1:0] max_i_d, max_i_q;
  logic [CNT_WIDTH-1:0] max_t_d, max_t_q;
  logic [CNT_WIDTH-1:0] rows_rem_d, rows_rem_q;
  logic [CNT_WIDTH-1:0] phase_d, phase_q;
  logic [ADDR_WIDTH-1:0] base_addr_d, base_addr_q;
  logic [NRW-1:0]       num_rows_d, num_rows_q;
  logic                 on_d, on_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;
  logic                 ctr_clear_s, ctr_adv_s, wrap_i_s, last_s;

  // Rows for the current tile: at most a full array, never below one row.
  function automatic logic [NRW-1:0] rows_clamp(input logic [CNT_WIDTH-1:0] rem);
    if (rem == '0) begin
      return NRW'(1);
    end else if (rem >= CNT_WIDTH'(ARRAY_N)) begin
      return NRW'(ARRAY_N);
    end else begin
      return NRW'(rem);
    end
  endfunction

  nested_iter_counter #(.CNT_WIDTH(CNT_WIDTH)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear_s),
    .advance (ctr_adv_s),
    .max_i   (max_i_q),
    .max_t   (max_t_q),
    .wrap_i  (wrap_i_s),
    .last    (last_s)
  );

  // Next-state, accumulator updates and registered-output decode.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    max_i_d     = max_i_q;
    max_t_d     = max_t_q;
    rows_rem_d  = rows_rem_q;
    phase_d     = phase_q;
    base_addr_d = base_addr_q;
    num_rows_d  = num_rows_q;
    ctr_clear_s = 1'b0;
    ctr_adv_s   = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          depth_d     = cfg_depth;
          max_i_d     = cfg_iter_i;
          max_t_d     = cfg_iter_t;
          rows_rem_d  = cfg_rows;
          base_addr_d = '0;
          ctr_clear_s = 1'b1;
          if ((cfg_depth == '0) || (cfg_iter_i == '0) || (cfg_iter_t == '0)) begin
            state_d = ST_DONE;
          end else begin
            num_rows_d = rows_clamp(cfg_rows);
            state_d    = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (tile_ready) begin
          phase_d = '0;
          state_d = ST_STREAM;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STREAM: begin
        if (phase_q == (depth_q - CNT_WIDTH'(1))) begin
          phase_d = '0;
          state_d = ST_DRAIN;
        end else begin
          phase_d = phase_q + CNT_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        // Address inputs must stay put until the last row's skewed enable ends.
        if (phase_q == CNT_WIDTH'(ARRAY_N - 1)) begin
          if (last_s) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            ctr_adv_s   = 1'b1;
            base_addr_d = base_addr_q + ADDR_WIDTH'(depth_q);
            if (wrap_i_s) begin
              rows_rem_d = (rows_rem_q >= CNT_WIDTH'(ARRAY_N)) ?
                           (rows_rem_q - CNT_WIDTH'(ARRAY_N)) : '0;
            end else begin
              rows_rem_d = rows_rem_q;
            end
            num_rows_d = rows_clamp(rows_rem_d);
            state_d    = ST_WAIT;
          end
        end else begin
          phase_d = phase_q + CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        // A drained run already pulsed done on entry; a zero-config run pulses here.
        done_d  = !done_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    on_d   = (state_d == ST_STREAM);
    busy_d = (state_d == ST_WAIT) || (state_d == ST_STREAM) || (state_d == ST_DRAIN) ||
             ((state_d == ST_DONE) && !done_d);
  end

  // State, configuration, accumulators and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      depth_q     <= '0;
      max_i_q     <= '0;
      max_t_q     <= '0;
      rows_rem_q  <= '0;
      phase_q     <= '0;
      base_addr_q <= '0;
      num_rows_q  <= '0;
      on_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      max_i_q     <= max_i_d;
      max_t_q     <= max_t_d;
      rows_rem_q  <= rows_rem_d;
      phase_q     <= phase_d;
      base_addr_q <= base_addr_d;
      num_rows_q  <= num_rows_d;
      on_q        <= on_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign on        = on_q;
  assign base_addr = base_addr_q;
  assign num_rows  = num_rows_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tile_feed_sequencer_a.sv
// Bench for tile_feed_sequencer_a: a 16-bit and a 4-bit address instance share
// stimulus; a tile-list reference model predicts every output each cycle.
module tb_tile_feed_sequencer_a;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        tile_ready = 1'b1;
  logic [15:0] cfg_depth = 16'd0, cfg_iter_i = 16'd0, cfg_iter_t = 16'd0, cfg_rows = 16'd0;

  logic        on, busy, done;
  logic [15:0] base_addr;
  logic [3:0]  num_rows;
  logic        on4, busy4, done4;
  logic [3:0]  base4;
  logic [3:0]  rows4;

  always #5 clk = ~clk;

  tile_feed_sequencer_a #(.ADDR_WIDTH(16), .ARRAY_N(N), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_depth(cfg_depth), .cfg_iter_i(cfg_iter_i),
    .cfg_iter_t(cfg_iter_t), .cfg_rows(cfg_rows), .tile_ready(tile_ready), .on(on),
    .base_addr(base_addr), .num_rows(num_rows), .busy(busy), .done(done));

  tile_feed_sequencer_a #(.ADDR_WIDTH(4), .ARRAY_N(N), .CNT_WIDTH(16)) dut4 (
    .clk(clk), .reset(reset), .start(start), .cfg_depth(cfg_depth), .cfg_iter_i(cfg_iter_i),
    .cfg_iter_t(cfg_iter_t), .cfg_rows(cfg_rows), .tile_ready(tile_ready), .on(on4),
    .base_addr(base4), .num_rows(rows4), .busy(busy4), .done(done4));

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: list of tiles plus a per-tile timeline
  typedef struct {
    logic [15:0] b;
    logic [3:0]  b4;
    logic [3:0]  r;
  } tile_t;
  tile_t tiles[$];

  logic        exp_on = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  logic [15:0] exp_base = 16'd0;
  logic [3:0]  exp_base4 = 4'd0, exp_rows = 4'd0;
  bit          running = 1'b0, zpend = 1'b0;
  int          tile_idx = 0, pos = 0, m_depth = 0;

  initial begin : model
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_on = 1'b0; exp_base = 16'd0; exp_base4 = 4'd0; exp_rows = 4'd0;
        exp_busy = 1'b0; exp_done = 1'b0; running = 1'b0; zpend = 1'b0;
      end else if (zpend) begin
        zpend = 1'b0; exp_busy = 1'b0; exp_done = 1'b1;
      end else if (!running) begin
        exp_done = 1'b0;
        if (start) begin
          exp_base = 16'd0; exp_base4 = 4'd0;
          if (cfg_depth == 16'd0 || cfg_iter_i == 16'd0 || cfg_iter_t == 16'd0) begin
            zpend = 1'b1; exp_busy = 1'b1;
          end else begin
            tiles.delete();
            for (int t = 0; t < int'(cfg_iter_t); t++) begin
              for (int i = 0; i < int'(cfg_iter_i); i++) begin
                tile_t  e;
                longint b;
                int     r;
                b = longint'(cfg_depth) * longint'(int'(cfg_iter_i) * t + i);
                r = int'(cfg_rows) - N * t;
                if (r > N) r = N;
                if (r < 1) r = 1;
                e.b = 16'(b % 65536);
                e.b4 = 4'(b % 16);
                e.r = 4'(r);
                tiles.push_back(e);
              end
            end
            m_depth = int'(cfg_depth);
            running = 1'b1; tile_idx = 0; pos = -1; exp_busy = 1'b1;
            exp_base = tiles[0].b; exp_base4 = tiles[0].b4; exp_rows = tiles[0].r;
          end
        end
      end else begin
        if (pos < 0) begin
          if (tile_ready) begin
            pos = 0; exp_on = 1'b1;
          end
        end else begin
          pos++;
          exp_on = (pos < m_depth);
          if (pos == m_depth + N) begin
            tile_idx++;
            if (tile_idx == tiles.size()) begin
              running = 1'b0; exp_busy = 1'b0; exp_done = 1'b1;
            end else begin
              pos = -1;
              exp_base = tiles[tile_idx].b; exp_base4 = tiles[tile_idx].b4;
              exp_rows = tiles[tile_idx].r;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("on", 32'(on), 32'(exp_on));
        chk("base_addr", 32'(base_addr), 32'(exp_base));
        chk("num_rows", 32'(num_rows), 32'(exp_rows));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("on_w4", 32'(on4), 32'(exp_on));
        chk("base_addr_w4", 32'(base4), 32'(exp_base4));
        chk("num_rows_w4", 32'(rows4), 32'(exp_rows));
      end
    end
  end

  // ---------------- record address inputs at each rising edge of on
  logic [15:0] rec_b[$];
  logic [3:0]  rec_b4[$];
  logic [3:0]  rec_r[$];
  logic        on_prev = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (on === 1'b1 && on_prev !== 1'b1) begin
        rec_b.push_back(base_addr);
        rec_b4.push_back(base4);
        rec_r.push_back(num_rows);
      end
      on_prev = on;
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_rec();
    rec_b.delete(); rec_b4.delete(); rec_r.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while ((exp_busy || exp_done || zpend || running) && n < 3000) begin
      tick(); n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_start(input int d, input int ii, input int it, input int r);
    wait_idle();
    cfg_depth = 16'(d); cfg_iter_i = 16'(ii); cfg_iter_t = 16'(it); cfg_rows = 16'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick(); n++;
    end
    if (n >= 3000) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_basic_run(input string tag);
    logic [15:0] lb[4];
    logic [3:0]  lr[4];
    lb = '{16'd0, 16'd4, 16'd8, 16'd12};
    lr = '{4'd8, 4'd8, 4'd4, 4'd4};
    chk({tag, "_tiles"}, 32'(rec_b.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rec_b.size()) begin
        chk({tag, "_base"}, 32'(rec_b[i]), 32'(lb[i]));
        chk({tag, "_rows"}, 32'(rec_r[i]), 32'(lr[i]));
      end
    end
  endtask

  // ---------------- main sequence
  initial begin : main
    logic [3:0] lb4[4];
    int n;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_on", 32'(on), 32'd0);
    chk("rst_base", 32'(base_addr), 32'd0);
    chk("rst_rows", 32'(num_rows), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // basic 2x2 tile run
    tile_ready = 1'b1;
    clear_rec();
    do_start(4, 2, 2, 12);
    wait_done();
    check_basic_run("basic");

    // zero-depth start: busy for one cycle, done two cycles after start
    do_start(0, 3, 3, 9);
    chk("zero_busy_k1", 32'(busy), 32'd1);
    chk("zero_done_k1", 32'(done), 32'd0);
    tick();
    chk("zero_done_k2", 32'(done), 32'd1);
    chk("zero_busy_k2", 32'(busy), 32'd0);
    tick();
    chk("zero_done_k3", 32'(done), 32'd0);

    // tile_ready stall before the second tile
    clear_rec();
    do_start(3, 3, 1, 8);
    n = 0;
    while (rec_b.size() < 1 && n < 100) begin tick(); n++; end
    chk("stall_first_tile", 32'(rec_b.size()), 32'd1);
    tile_ready = 1'b0;
    repeat (3 + N + 2) tick();
    for (int i = 0; i < 20; i++) begin
      chk("stall_on", 32'(on), 32'd0);
      chk("stall_base", 32'(base_addr), 32'd3);
      tick();
    end
    tile_ready = 1'b1;
    tick();
    chk("stall_resume_on", 32'(on), 32'd1);
    chk("stall_resume_base", 32'(base_addr), 32'd3);
    wait_done();

    // reset during the third STREAM cycle, then a clean rerun
    do_start(5, 2, 1, 8);
    n = 0;
    while (on !== 1'b1 && n < 100) begin tick(); n++; end
    tick(); tick();
    chk("pre_reset_on", 32'(on), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_reset_on", 32'(on), 32'd0);
    chk("mid_reset_base", 32'(base_addr), 32'd0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    clear_rec();
    do_start(4, 2, 2, 12);
    wait_done();
    check_basic_run("after_reset");

    // start while busy with different config is ignored
    clear_rec();
    do_start(4, 2, 2, 12);
    repeat (5) tick();
    cfg_depth = 16'd7; cfg_iter_i = 16'd1; cfg_iter_t = 16'd5; cfg_rows = 16'd40;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check_basic_run("busy_start");

    // 4-bit address wrap
    clear_rec();
    do_start(6, 3, 1, 8);
    wait_done();
    lb4 = '{4'd0, 4'd6, 4'd12, 4'd2};
    chk("w4a_tiles", 32'(rec_b4.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < rec_b4.size()) chk("w4a_base", 32'(rec_b4[i]), 32'(lb4[i]));
    clear_rec();
    do_start(6, 4, 1, 8);
    wait_done();
    chk("w4b_tiles", 32'(rec_b4.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < rec_b4.size()) chk("w4b_base", 32'(rec_b4[i]), 32'(lb4[i]));

    // randomized runs with ready backpressure and ignored restarts
    for (int run = 0; run < 25; run++) begin
      do_start(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 30)));
      n = 0;
      while (!exp_done && n < 3000) begin
        tile_ready = ($urandom_range(0, 9) < 7);
        if (exp_busy && $urandom_range(0, 19) == 0) begin
          cfg_depth = 16'($urandom_range(0, 9));
          cfg_iter_i = 16'($urandom_range(0, 5));
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick(); n++;
      end
      start = 1'b0;
      tile_ready = 1'b1;
      if (n >= 3000) chk("rand_timeout", 32'd1, 32'd0);
    end

    wait_idle();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
